const_mod_seq: RTL

- Sequential, parametrised successor to the fixed 64-bit mod-11 combinational remainder unit.
- Computes R = X mod D for any odd constant divisor D and any operand width W.
- Consumes CHUNK operand bits per cycle, MSB first, using a Horner residue update: r <= (r*2^CHUNK + chunk) mod D, implemented as a constant LUT.
- Valid/ready handshake on both sides, one operation in flight; sits in the datapath's constant-division group, replacing unrolled per-width instances.

---
 rtl/const_mod_seq_if.sv | 24 ++
 rtl/const_mod_seq.sv | 90 +++++++++
 2 files changed

// File: rtl/const_mod_seq_if.sv
// Operand/result handshake bundle for the sequential constant-modulo unit.
// master drives operands and result acceptance; slave is the remainder engine.
interface const_mod_seq_if #(
    parameter int W  = 64,
    parameter int RW = 4
);
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  X;
    logic          out_valid;
    logic          out_ready;
    logic [RW-1:0] R;
    logic          busy;

    modport master (
        output in_valid, X, out_ready,
        input  in_ready, out_valid, R, busy
    );

    modport slave (
        input  in_valid, X, out_ready,
        output in_ready, out_valid, R, busy
    );
endinterface

// File: rtl/const_mod_seq.sv
// X mod D for constant odd D, CHUNK bits per cycle MSB first; result N=ceil(W/CHUNK) cycles after accept.
// One operation in flight: in_ready only in IDLE, result held in DONE until out_ready.
module const_mod_seq #(
    parameter int W     = 64,
    parameter int D     = 11,
    parameter int CHUNK = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    const_mod_seq_if.slave  io
);
    localparam int RW = $clog2(D);
    localparam int N  = (W + CHUNK - 1) / CHUNK;
    localparam int SW = N * CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int LN = D << CHUNK;

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [SW-1:0] sr;
    logic [RW-1:0] r;
    logic [RW-1:0] res;
    logic [CW-1:0] cnt;
    logic [RW-1:0] r_nxt;
    logic          last;

    // Residue table: entry {r, chunk} holds (r*2^CHUNK + chunk) mod D; r < D keeps the index in range.
    logic [RW-1:0] lut [LN];
    generate
        for (genvar i = 0; i < LN; i++) begin : g_lut
            assign lut[i] = RW'(i % D);
        end
    endgenerate

    assign r_nxt = lut[{r, sr[SW-1 -: CHUNK]}];
    assign last  = (cnt == CW'(N - 1));

    always_comb begin
        state_nxt    = state;
        io.in_ready  = 1'b0;
        io.out_valid = 1'b0;
        io.busy      = 1'b1;
        io.R         = res;
        case (state)
            IDLE: begin
                io.in_ready = 1'b1;
                io.busy     = 1'b0;
                if (io.in_valid) state_nxt = ACCUM;
            end
            ACCUM: begin
                if (last) state_nxt = DONE;
            end
            DONE: begin
                io.out_valid = 1'b1;
                if (io.out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            sr    <= '0;
            r     <= '0;
            cnt   <= '0;
            res   <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (io.in_valid) begin
                        sr  <= SW'(io.X);
                        r   <= '0;
                        cnt <= '0;
                    end
                end
                ACCUM: begin
                    r   <= r_nxt;
                    sr  <= sr << CHUNK;
                    cnt <= cnt + 1'b1;
                    if (last) res <= r_nxt;
                end
                default: ;
            endcase
        end
    end
endmodule
